// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants.
package riscv_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    localparam int unsigned WORD_INC      = 4;
    // Upper bound on in-flight requests plus buffered instructions.
    localparam int unsigned FETCH_CREDITS = 2;

endpackage

// File: rtl/fetch_fifo.sv
// Depth-2 FIFO with synchronous flush; simultaneous write and read allowed when full.
module fetch_fifo #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         flush,
    input  logic         wr,
    input  logic [W-1:0] wdata,
    input  logic         rd,
    output logic         valid,
    output logic [W-1:0] rdata,
    output logic [1:0]   count
);

    logic [1:0][W-1:0] mem;
    logic              wptr;
    logic              rptr;
    logic              do_wr;
    logic              do_rd;

    assign do_rd = rd && (count != 2'd0);
    assign do_wr = wr && ((count != 2'd2) || do_rd);
    assign valid = (count != 2'd0);
    assign rdata = mem[rptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem   <= '0;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            count <= 2'd0;
        end else if (flush) begin
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (do_wr) begin
                mem[wptr] <= wdata;
                wptr      <= ~wptr;
            end
            if (do_rd) rptr <= ~rptr;
            count <= count + 2'(do_wr) - 2'(do_rd);
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Credit-limited instruction fetch: issues word requests, tags responses with their
// PC, buffers up to two instructions and discards stale responses after a redirect.
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rstn,
    output logic            o_im_req,
    output logic [XLEN-1:0] o_im_addr,
    input  logic            i_im_gnt,
    input  logic            i_im_rvalid,
    input  logic [XLEN-1:0] i_im_rdata,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_instr_valid,
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_pc,
    input  logic            i_instr_ready
);

    fetch_state_e         state;
    logic [XLEN-1:0]      fetch_pc;
    logic [1:0]           outst;
    logic [1:0]           discard;
    logic [1:0]           fcnt;
    logic [1:0][XLEN-1:0] tagq;
    logic                 tw;
    logic                 tr;
    logic                 grant;
    logic                 rsp_ok;
    logic [1:0]           outst_nx;
    logic                 fifo_wr;
    logic [2*XLEN-1:0]    head;

    // Request depends only on registered state, so it cannot drop before grant
    // except through a redirect.
    assign o_im_req  = (state == RUN) &&
                       (({1'b0, outst} + {1'b0, fcnt}) < 3'(FETCH_CREDITS));
    assign o_im_addr = fetch_pc;
    assign grant     = o_im_req && i_im_gnt;
    assign rsp_ok    = i_im_rvalid && (outst != 2'd0);
    assign outst_nx  = outst + 2'(grant) - 2'(rsp_ok);
    assign fifo_wr   = (state == RUN) && rsp_ok && !i_redirect;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= BOOT;
            fetch_pc <= RESET_PC;
            outst    <= 2'd0;
            discard  <= 2'd0;
            tagq     <= '0;
            tw       <= 1'b0;
            tr       <= 1'b0;
        end else if (i_redirect) begin
            // Everything still in flight, including a same-cycle grant, becomes stale.
            fetch_pc <= i_redirect_pc & ~XLEN'(3);
            outst    <= outst_nx;
            discard  <= outst_nx;
            tw       <= 1'b0;
            tr       <= 1'b0;
            state    <= (outst_nx != 2'd0) ? DRAIN : RUN;
        end else begin
            outst <= outst_nx;
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (grant) begin
                        fetch_pc <= fetch_pc + XLEN'(WORD_INC);
                        tagq[tw] <= fetch_pc;
                        tw       <= ~tw;
                    end
                    if (rsp_ok) tr <= ~tr;
                end
                DRAIN: begin
                    if (rsp_ok) begin
                        discard <= discard - 2'd1;
                        if (discard == 2'd1) state <= RUN;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

    fetch_fifo #(.W(2*XLEN)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .flush (i_redirect),
        .wr    (fifo_wr),
        .wdata ({tagq[tr], i_im_rdata}),
        .rd    (i_instr_ready && !i_redirect),
        .valid (o_instr_valid),
        .rdata (head),
        .count (fcnt)
    );

    assign {o_pc, o_instr} = head;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: streaming, stall, redirect/drain, wrap and reset.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rstn;
    logic        o_im_req;
    logic [31:0] o_im_addr;
    logic        i_im_gnt;
    logic        i_im_rvalid;
    logic [31:0] i_im_rdata;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_instr_valid;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        i_instr_ready;

    logic        auto_rsp = 1'b0;
    logic        a_rvalid = 1'b0;
    logic [31:0] a_rdata  = '0;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        mg;
    logic [31:0] mga;

    int          nvec = 0;
    int          nmis = 0;
    int          ncons;
    logic [31:0] exp_pc;

    always #5 clk = ~clk;

    assign i_im_rvalid = auto_rsp ? a_rvalid : m_rvalid;
    assign i_im_rdata  = auto_rsp ? a_rdata  : m_rdata;

    instruction_fetch #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .o_im_req      (o_im_req),
        .o_im_addr     (o_im_addr),
        .i_im_gnt      (i_im_gnt),
        .i_im_rvalid   (i_im_rvalid),
        .i_im_rdata    (i_im_rdata),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_instr_valid (o_instr_valid),
        .o_instr       (o_instr),
        .o_pc          (o_pc),
        .i_instr_ready (i_instr_ready)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0013;
    endfunction

    // Memory model: answers each grant exactly one cycle later.
    always @(posedge clk) begin
        mg  = auto_rsp && rstn && o_im_req && i_im_gnt;
        mga = o_im_addr;
        #1;
        a_rvalid = mg;
        a_rdata  = instr_of(mga);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Checks the current cycle first, then advances to the next negedge.
    task run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            if (o_instr_valid && i_instr_ready) begin
                chk("pc", o_pc, exp_pc);
                chk("instr", o_instr, instr_of(exp_pc));
                exp_pc = exp_pc + 32'd4;
                ncons++;
            end
            @(negedge clk);
        end
    endtask

    task drain();
        i_im_gnt = 1'b0;
        run_cycles(4);
    endtask

    initial begin
        rstn = 1'b0; i_im_gnt = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;
        i_instr_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        exp_pc = '0; ncons = 0;
        repeat (2) @(negedge clk);
        chk("rst_req", o_im_req, 0);
        chk("rst_addr", o_im_addr, 32'h0);
        chk("rst_valid", o_instr_valid, 0);
        chk("rst_instr", o_instr, 32'h0);
        chk("rst_pc", o_pc, 32'h0);

        // streaming from reset
        rstn = 1'b1; i_im_gnt = 1'b1; auto_rsp = 1'b1; i_instr_ready = 1'b1;
        #1 chk("boot_req", o_im_req, 0);
        @(negedge clk);
        chk("run_req", o_im_req, 1);
        chk("run_addr", o_im_addr, 32'h0);
        chk("lat1_valid", o_instr_valid, 0);
        @(negedge clk);
        chk("lat2_valid", o_instr_valid, 0);
        @(negedge clk);
        chk("lat3_valid", o_instr_valid, 1);
        run_cycles(30);
        chk("stream_cnt", ncons >= 10, 1);

        // decode stall: two buffered, request blocked
        i_instr_ready = 1'b0;
        run_cycles(10);
        chk("stall_req", o_im_req, 0);
        chk("stall_valid", o_instr_valid, 1);
        chk("stall_head", o_pc, exp_pc);
        i_im_gnt = 1'b0; i_instr_ready = 1'b1; ncons = 0;
        run_cycles(5);
        chk("stall_buffered", ncons, 2);
        chk("stall_empty", o_instr_valid, 0);
        i_im_gnt = 1'b1;
        run_cycles(12);

        // redirect with two outstanding
        drain();
        chk("pre_redir_addr", o_im_addr, exp_pc);
        auto_rsp = 1'b0; i_im_gnt = 1'b1;
        run_cycles(2);
        i_im_gnt = 1'b0;
        chk("credit_req", o_im_req, 0);
        i_redirect = 1'b1; i_redirect_pc = 32'h103;
        run_cycles(1);
        i_redirect = 1'b0; i_im_gnt = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hBAD0_0001;
        chk("drain_req", o_im_req, 0);
        chk("drain_addr", o_im_addr, 32'h100);
        chk("drain_valid", o_instr_valid, 0);
        run_cycles(1);
        chk("drop1_valid", o_instr_valid, 0);
        chk("drop1_req", o_im_req, 0);
        run_cycles(1);
        m_rvalid = 1'b0;
        chk("drop2_valid", o_instr_valid, 0);
        chk("resume_req", o_im_req, 1);
        chk("resume_addr", o_im_addr, 32'h100);
        exp_pc = 32'h100; ncons = 0; auto_rsp = 1'b1;
        run_cycles(10);
        chk("redir_cnt", ncons >= 3, 1);

        // redirect coincident with grant and response
        drain();
        auto_rsp = 1'b0; i_im_gnt = 1'b1;
        run_cycles(1);
        chk("coin_req", o_im_req, 1);
        m_rvalid = 1'b1; m_rdata = instr_of(exp_pc);
        i_redirect = 1'b1; i_redirect_pc = 32'h200;
        run_cycles(1);
        i_redirect = 1'b0; m_rdata = 32'hBAD0_0002;
        chk("coin_valid", o_instr_valid, 0);
        chk("coin_drain_req", o_im_req, 0);
        chk("coin_addr", o_im_addr, 32'h200);
        run_cycles(1);
        m_rvalid = 1'b0;
        chk("coin_valid2", o_instr_valid, 0);
        chk("coin_resume", o_im_req, 1);
        chk("coin_addr2", o_im_addr, 32'h200);
        exp_pc = 32'h200; ncons = 0; auto_rsp = 1'b1;
        run_cycles(10);
        chk("coin_cnt", ncons >= 3, 1);

        // address wrap
        drain();
        i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFC;
        run_cycles(1);
        i_redirect = 1'b0;
        chk("wrap_req", o_im_req, 1);
        chk("wrap_addr", o_im_addr, 32'hFFFF_FFFC);
        i_im_gnt = 1'b1; exp_pc = 32'hFFFF_FFFC; ncons = 0;
        run_cycles(1);
        chk("wrap_next", o_im_addr, 32'h0);
        run_cycles(10);
        chk("wrap_cnt", ncons >= 3, 1);

        // reset with two outstanding
        drain();
        auto_rsp = 1'b0; i_im_gnt = 1'b1;
        run_cycles(2);
        i_im_gnt = 1'b0;
        rstn = 1'b0;
        #1;
        chk("mid_rst_req", o_im_req, 0);
        chk("mid_rst_addr", o_im_addr, 32'h0);
        chk("mid_rst_valid", o_instr_valid, 0);
        chk("mid_rst_instr", o_instr, 32'h0);
        chk("mid_rst_pc", o_pc, 32'h0);
        @(negedge clk);
        rstn = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hBAD0_0003;
        run_cycles(3);
        m_rvalid = 1'b0;
        chk("late_valid", o_instr_valid, 0);
        chk("late_req", o_im_req, 1);
        chk("late_addr", o_im_addr, 32'h0);
        auto_rsp = 1'b1; i_im_gnt = 1'b1; exp_pc = 32'h0; ncons = 0;
        run_cycles(12);
        chk("restart_cnt", ncons >= 3, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter XLEN, default 32, data/address width.
REQ-002 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 o_im_req  output  1  instruction memory request valid.
REQ-006 o_im_addr  output  XLEN  request byte address, word-aligned.
REQ-007 i_im_gnt  input  1  memory accepts request when o_im_req and i_im_gnt are both high.
REQ-008 i_im_rvalid  input  1  response valid, in request order, at least 1 cycle after grant.
REQ-009 i_im_rdata  input  XLEN  instruction word for the oldest outstanding request.
REQ-010 i_redirect  input  1  control-flow change (branch/jump taken).
REQ-011 i_redirect_pc  input  XLEN  redirect target; bits [1:0] ignored and forced 0.
REQ-012 o_instr_valid  output  1  instruction available to decode.
REQ-013 o_instr  output  XLEN  instruction word, feeds decoder i_im_rdata.
REQ-014 o_pc  output  XLEN  address of o_instr.
REQ-015 i_instr_ready  input  1  decode consumes instruction when o_instr_valid and i_instr_ready are high.

Function
REQ-016 FSM states BOOT, RUN, DRAIN; reset state BOOT.
REQ-017 BOOT -> RUN unconditionally after one cycle; no request issued in BOOT.
REQ-018 Fetch PC register holds next request address; advances by 4 on each grant, wrapping modulo 2^XLEN.
REQ-019 Credit rule: o_im_req high in RUN only when outstanding_count + fifo_count < 2.
REQ-020 o_im_req and o_im_addr, once asserted, remain stable until grant unless a redirect occurs.
REQ-021 Outstanding counter (0..2): +1 on grant, -1 on rvalid, both same cycle -> unchanged.
REQ-022 rvalid in RUN writes {PC of oldest outstanding request, i_im_rdata} into a 2-entry FIFO; the request-PC is tracked in a 2-entry tag queue.
REQ-023 o_instr_valid = FIFO non-empty; o_instr/o_pc = FIFO head; response-to-o_instr_valid latency 1 cycle.
REQ-024 FIFO supports write and read in the same cycle when full; overflow is impossible under REQ-019.
REQ-025 Redirect, any state: FIFO flushed, o_instr_valid low the next cycle, fetch PC <= i_redirect_pc & ~3.
REQ-026 Redirect with outstanding (after counting same-cycle grant, minus same-cycle rvalid) > 0: enter DRAIN with discard count = that value; otherwise stay in or enter RUN.
REQ-027 DRAIN: no requests; each rvalid decrements discard count and is dropped; discard count 0 -> RUN.
REQ-028 Redirect in DRAIN: target updated, discard count recomputed per REQ-026.
REQ-029 Redirect has priority over same-cycle consume, response write and PC increment.
REQ-030 rvalid with zero outstanding is ignored.

Reset
REQ-031 rstn low: state BOOT, fetch PC = RESET_PC, counters 0, FIFO empty, immediately (asynchronously).
REQ-032 Reset values: o_im_req 0, o_im_addr RESET_PC, o_instr_valid 0, o_instr 0, o_pc 0.
REQ-033 Reset mid-transaction abandons outstanding requests; responses arriving after reset release are ignored per REQ-030.

Structure
REQ-034 FetchState enum and the word-increment constant (4) in riscv_pkg.
REQ-035 Sub-module fetch_fifo: parameterised depth-2 FIFO with flush, instantiated once for {pc, instr}.

Verification
REQ-036 Reset release, gnt tied high, rvalid one cycle after grant, ready high -> o_pc 0,4,8,... one per cycle after 3-cycle latency.
REQ-037 i_instr_ready low 10 cycles -> exactly 2 instructions buffered, o_im_req low, no lost/duplicated PCs after release.
REQ-038 Redirect to 0x103 with 2 outstanding -> DRAIN, 2 responses dropped, next request address 0x100, next o_pc 0x100.
REQ-039 Redirect coincident with rvalid and grant -> that response dropped, granted request discarded, no stale o_instr_valid.
REQ-040 Fetch PC 0xFFFFFFFC -> next request address 0x00000000.
REQ-041 rstn low while 2 requests outstanding -> outputs at reset values, late rvalid ignored, fetch restarts at RESET_PC.
